// File: rtl/mem_ctrl.sv
// mem_ctrl: memory controller between the CPU core and a byte-wide,
// single-port, synchronous-read RAM.
//
// It arbitrates the instruction-fetch (IF) and data (MEM) ports onto one RAM.
// MEM wins ties because it belongs to the older instruction. Each 32-bit word
// access is serialised into four little-endian byte transfers. Each requester
// gets a one-cycle done pulse.
//
// Optional feature: define MEM_CTRL_IF_BUF_EN to add a one-entry fetch buffer.
// A fetch that hits the buffer completes the cycle after acceptance and does
// not touch the RAM.
//
// Ports:
//   clk, rst                  rising-edge clock; asynchronous active-high reset
//   if_req/if_addr            fetch request (held until if_done) and byte address
//   if_data/if_done           fetched word (held until next fetch) and done pulse
//   mem_req/mem_we/mem_addr   data request, 1=store, byte address
//   mem_sel/mem_wdata         store byte enables and store data
//   mem_rdata/mem_done        loaded word (held) and done pulse
//   ram_addr/ram_we/ram_din   RAM byte address, write strobe, write data
//   ram_dout                  RAM read data, one cycle after the address edge
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);
  localparam int BASE_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                tail_q, tail_d;     // RD: last byte still in flight from the RAM
  logic                own_if_q, own_if_d; // current read belongs to the IF port
  logic [BASE_W-1:0]   base_q, base_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [23:0]         rbuf_q, rbuf_d;     // bytes 0..2 of a read; byte 3 goes straight out
  logic [31:0]         if_data_q, if_data_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [7:0]          ram_din_q, ram_din_d;
  logic                ibuf_hit;
  logic [31:0]         ibuf_word;
  logic [1:0]          cnt_nxt;

  // Only the word-address bits inside the RAM are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0],
                              mem_addr[31:ADDR_W], mem_addr[1:0]};

  assign cnt_nxt = cnt_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    own_if_d    = own_if_q;
    base_d      = base_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          base_d     = mem_addr[ADDR_W-1:2];
          sel_d      = mem_sel;
          wdata_d    = mem_wdata;
          own_if_d   = 1'b0;
          cnt_d      = 2'd0;
          tail_d     = 1'b0;
          ram_addr_d = {mem_addr[ADDR_W-1:2], 2'b00};
          if (mem_we) begin
            state_d   = S_WR;
            ram_din_d = mem_wdata[7:0];
            ram_we_d  = mem_sel[0];
          end else begin
            state_d   = S_RD;
          end
        end else if (if_req) begin
          if (ibuf_hit) begin
            if_data_d = ibuf_word;
            if_done_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            base_d     = if_addr[ADDR_W-1:2];
            own_if_d   = 1'b1;
            cnt_d      = 2'd0;
            tail_d     = 1'b0;
            ram_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
            state_d    = S_RD;
          end
        end
      end
      S_RD: begin
        if (tail_q) begin
          if (own_if_q) begin
            if_data_d   = {ram_dout, rbuf_q};
            if_done_d   = 1'b1;
          end else begin
            mem_rdata_d = {ram_dout, rbuf_q};
            mem_done_d  = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          // ram_dout lags ram_addr by one cycle, so it carries byte cnt-1.
          case (cnt_q)
            2'd1:    rbuf_d[7:0]   = ram_dout;
            2'd2:    rbuf_d[15:8]  = ram_dout;
            2'd3:    rbuf_d[23:16] = ram_dout;
            default: ;
          endcase
          if (cnt_q == 2'd3) begin
            tail_d = 1'b1;
          end else begin
            cnt_d      = cnt_nxt;
            ram_addr_d = {base_q, cnt_nxt};
          end
        end
      end
      S_WR: begin
        if (cnt_q == 2'd3) begin
          mem_done_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d      = cnt_nxt;
          ram_addr_d = {base_q, cnt_nxt};
          ram_din_d  = word_byte(wdata_q, cnt_nxt);
          ram_we_d   = sel_q[cnt_nxt];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      tail_q      <= 1'b0;
      own_if_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      own_if_q    <= own_if_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    sel_q   <= sel_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

`ifdef MEM_CTRL_IF_BUF_EN
  logic              ibuf_vld_q, ibuf_vld_d;
  logic [BASE_W-1:0] ibuf_tag_q, ibuf_tag_d;
  logic [31:0]       ibuf_data_q, ibuf_data_d;

  assign ibuf_hit  = ibuf_vld_q && (ibuf_tag_q == if_addr[ADDR_W-1:2]);
  assign ibuf_word = ibuf_data_q;

  always_comb begin
    ibuf_vld_d  = ibuf_vld_q;
    ibuf_tag_d  = ibuf_tag_q;
    ibuf_data_d = ibuf_data_q;
    // A store to the buffered word makes the copy stale.
    if (state_q == S_IDLE && mem_req && mem_we &&
        mem_addr[ADDR_W-1:2] == ibuf_tag_q)
      ibuf_vld_d = 1'b0;
    if (state_q == S_RD && tail_q && own_if_q) begin
      ibuf_vld_d  = 1'b1;
      ibuf_tag_d  = base_q;
      ibuf_data_d = {ram_dout, rbuf_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ibuf_vld_q <= 1'b0;
    else     ibuf_vld_q <= ibuf_vld_d;
  end

  always_ff @(posedge clk) begin
    ibuf_tag_q  <= ibuf_tag_d;
    ibuf_data_q <= ibuf_data_d;
  end
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_word = '0;
`endif

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int ADDR_W = 17;
  localparam int RD_LAT = 5;
  localparam int WR_LAT = 4;
`ifdef MEM_CTRL_IF_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [3:0]        mem_sel;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Byte-wide synchronous RAM with a backdoor write port for preloading.
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [7:0]        bd_din;
  always @(posedge clk) begin
    if (bd_we)       ram[bd_addr] <= bd_din;
    else if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Reference model: memory image plus fetch-buffer state.
  logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
  bit                ref_buf_vld = 1'b0;
  logic [ADDR_W-3:0] ref_buf_tag = '0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[ADDR_W-1:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
    int b;
    b = int'(a[ADDR_W-1:2]) * 4;
    for (int k = 0; k < 4; k++) if (sel[k]) ref_mem[b+k] = wd[8*k +: 8];
    if (ref_buf_vld && ref_buf_tag == a[ADDR_W-1:2]) ref_buf_vld = 1'b0;
  endtask

  function automatic int ref_fetch_lat(input logic [31:0] a);
    return (BUF_EN && ref_buf_vld && ref_buf_tag == a[ADDR_W-1:2]) ? 0 : RD_LAT;
  endfunction

  task automatic ref_fetch_done(input logic [31:0] a);
    if (BUF_EN) begin
      ref_buf_vld = 1'b1;
      ref_buf_tag = a[ADDR_W-1:2];
    end
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    bd_addr = a[ADDR_W-1:0];
    bd_din  = v;
    ref_mem[a] = v;
    @(posedge clk); #1;
  endtask

  // Issues one fetch and waits for if_done (bounded); lat=-1 on timeout.
  task automatic drive_if(input logic [31:0] a, output logic [31:0] d,
                          output int lat, output bit saw_we);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a;
    lat = -1; d = '0; saw_we = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) if_addr = $urandom;
      if (ram_we) saw_we = 1'b1;
      if (if_done) begin lat = k; d = if_data; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic drive_mem(input logic we, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] wd, output logic [31:0] d, output int lat);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_sel = sel; mem_wdata = wd;
    lat = -1; d = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_sel = 4'($urandom); mem_we = 1'($urandom);
      end
      if (mem_done) begin lat = k; d = mem_rdata; break; end
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({if_done, mem_done, ram_we} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 000", {if_done, mem_done, ram_we});
    end
    checks++;
    if ({if_data, mem_rdata, ram_addr, ram_din} !== '0) begin
      failures++;
      $display("FAIL reset_data: if_data=%h mem_rdata=%h ram_addr=%h ram_din=%h expected all 0",
               if_data, mem_rdata, ram_addr, ram_din);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] d, a;
    int lat, exp_lat;
    bit we;
    exp_lat = ref_fetch_lat(32'h100);
    drive_if(32'h100, d, lat, we);
    ref_fetch_done(32'h100);
    checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL fetch_data: got %h expected 44332211", d); end
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL fetch_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL fetch_no_write: ram_we seen %b expected 0", we); end
    @(posedge clk); #1;
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_pulse: if_done %b expected 0", if_done); end
    checks++; if (if_data !== 32'h44332211) begin failures++; $display("FAIL fetch_hold: got %h expected 44332211", if_data); end
    // Low address bits and bits above the RAM are ignored.
    a = 32'h102 | ($urandom & 32'hFFFE_0000);
    exp_lat = ref_fetch_lat(a);
    drive_if(a, d, lat, we);
    ref_fetch_done(a);
    checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL fetch_unaligned: got %h expected 44332211", d); end
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL fetch_unaligned_lat: got %0d expected %0d", lat, exp_lat); end
  endtask

  task automatic test_hold_extra;
    int e1, e2, t1, t2, n;
    logic [31:0] d2;
    e1 = ref_fetch_lat(32'h100);
    ref_fetch_done(32'h100);
    e2 = e1 + 2 + ref_fetch_lat(32'h100);
    ref_fetch_done(32'h100);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    t1 = -1; t2 = -1; n = 0; d2 = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (if_done) begin
        n++;
        if (n == 1) t1 = k;
        else begin t2 = k; d2 = if_data; break; end
      end
    end
    if_req = 1'b0;
    checks++; if (t1 !== e1) begin failures++; $display("FAIL hold_first_done: got %0d expected %0d", t1, e1); end
    checks++; if (t2 !== e2) begin failures++; $display("FAIL hold_second_done: got %0d expected %0d", t2, e2); end
    checks++; if (d2 !== 32'h44332211) begin failures++; $display("FAIL hold_second_data: got %h expected 44332211", d2); end
  endtask

  task automatic test_store;
    logic [31:0] d;
    int lat;
    drive_mem(1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, d, lat);
    ref_store(32'h200, 4'b0101, 32'hAABBCCDD);
    checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL store_latency: got %0d expected %0d", lat, WR_LAT); end
    drive_mem(1'b0, 32'h200, 4'b1111, 32'h0, d, lat);
    checks++; if (d !== 32'h00BB00DD) begin failures++; $display("FAIL store_readback: got %h expected 00BB00DD", d); end
    checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL load_latency: got %0d expected %0d", lat, RD_LAT); end
    checks++; if (if_data !== 32'h44332211) begin failures++; $display("FAIL if_data_held: got %h expected 44332211", if_data); end
    // Store with no byte enables still takes the full write time.
    drive_mem(1'b1, 32'h200, 4'b0000, $urandom, d, lat);
    checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL sel0_latency: got %0d expected %0d", lat, WR_LAT); end
    drive_mem(1'b0, 32'h200, 4'b0000, 32'h0, d, lat);
    checks++; if (d !== 32'h00BB00DD) begin failures++; $display("FAIL sel0_readback: got %h expected 00BB00DD", d); end
  endtask

  task automatic test_arbitration;
    int tm, ti, exp_if;
    logic [31:0] md, id;
    exp_if = RD_LAT + 2 + ref_fetch_lat(32'h104);
    ref_fetch_done(32'h104);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'($urandom);
    if_req = 1'b1; if_addr = 32'h104;
    tm = -1; ti = -1; md = '0; id = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (mem_done) begin tm = k; md = mem_rdata; mem_req = 1'b0; end
      if (if_done)  begin ti = k; id = if_data;   if_req = 1'b0; end
      if (tm >= 0 && ti >= 0) break;
    end
    mem_req = 1'b0; if_req = 1'b0;
    checks++; if (tm !== RD_LAT) begin failures++; $display("FAIL arb_mem_done: got %0d expected %0d", tm, RD_LAT); end
    checks++; if (ti !== exp_if) begin failures++; $display("FAIL arb_if_done: got %0d expected %0d", ti, exp_if); end
    checks++; if (md !== ref_word(32'h200)) begin failures++; $display("FAIL arb_mem_data: got %h expected %h", md, ref_word(32'h200)); end
    checks++; if (id !== ref_word(32'h104)) begin failures++; $display("FAIL arb_if_data: got %h expected %h", id, ref_word(32'h104)); end
  endtask

`ifdef MEM_CTRL_IF_BUF_EN
  task automatic test_buffer;
    logic [31:0] d;
    logic [ADDR_W-1:0] ra;
    int lat, exp_lat;
    bit we;
    exp_lat = ref_fetch_lat(32'h100);
    drive_if(32'h100, d, lat, we);
    ref_fetch_done(32'h100);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL buf_first_lat: got %0d expected %0d", lat, exp_lat); end
    ra = ram_addr;
    drive_if(32'h100, d, lat, we);
    checks++; if (lat !== 0) begin failures++; $display("FAIL buf_hit_lat: got %0d expected 0", lat); end
    checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL buf_hit_data: got %h expected 44332211", d); end
    checks++; if (ram_addr !== ra) begin failures++; $display("FAIL buf_hit_ram_addr: got %h expected %h", ram_addr, ra); end
    drive_mem(1'b1, 32'h100, 4'b0001, 32'h000000EE, d, lat);
    ref_store(32'h100, 4'b0001, 32'h000000EE);
    drive_if(32'h100, d, lat, we);
    ref_fetch_done(32'h100);
    checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL buf_inval_lat: got %0d expected %0d", lat, RD_LAT); end
    checks++; if (d !== 32'h443322EE) begin failures++; $display("FAIL buf_inval_data: got %h expected 443322EE", d); end
  endtask
`endif

  task automatic test_reset_async;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h104;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #($urandom_range(1, 3));
    rst = 1'b1; if_req = 1'b0;
    #1;
    checks++;
    if ({if_done, mem_done, ram_we, if_data, mem_rdata, ram_addr, ram_din} !== '0) begin
      failures++;
      $display("FAIL async_reset: if_data=%h mem_rdata=%h ram_addr=%h ram_din=%h strobes=%b expected all 0",
               if_data, mem_rdata, ram_addr, ram_din, {if_done, mem_done, ram_we});
    end
    ref_buf_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] wd, d, exp;
    int lat, dones;
    wd = $urandom;
    exp = {ref_mem[32'h303], ref_mem[32'h302], wd[15:8], wd[7:0]};
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_sel = 4'hF; mem_wdata = wd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    rst = 1'b1; mem_req = 1'b0;
    ref_mem[32'h300] = wd[7:0];
    ref_mem[32'h301] = wd[15:8];
    ref_buf_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mem_done || if_done || ram_we) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_quiet: activity cycles %0d expected 0", dones); end
    drive_mem(1'b0, 32'h300, 4'h0, 32'h0, d, lat);
    checks++; if (d !== exp) begin failures++; $display("FAIL abort_partial: got %h expected %h", d, exp); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, wd, last_if;
    logic [3:0] sel;
    int lat, exp_lat, op, word;
    bit we;
    last_if = 32'h0;
    for (int i = 0; i < 30; i++) begin
      word = ($urandom_range(0, 7) == 0) ? 32'h7FFF : $urandom_range(32'h40, 32'hFF);
      a = (($urandom & 32'hFFFE_0000) | (word << 2) | ($urandom & 32'h3));
      op = $urandom_range(0, 2);
      if (op == 0) begin
        drive_mem(1'b0, a, 4'($urandom), 32'($urandom), d, lat);
        checks++; if (d !== ref_word(a)) begin failures++; $display("FAIL rnd_load[%0d]: addr %h got %h expected %h", i, a, d, ref_word(a)); end
        checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL rnd_load_lat[%0d]: got %0d expected %0d", i, lat, RD_LAT); end
        checks++; if (if_data !== last_if) begin failures++; $display("FAIL rnd_if_held[%0d]: got %h expected %h", i, if_data, last_if); end
      end else if (op == 1) begin
        sel = 4'($urandom); wd = $urandom;
        drive_mem(1'b1, a, sel, wd, d, lat);
        ref_store(a, sel, wd);
        checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL rnd_store_lat[%0d]: got %0d expected %0d", i, lat, WR_LAT); end
      end else begin
        exp_lat = ref_fetch_lat(a);
        drive_if(a, d, lat, we);
        ref_fetch_done(a);
        last_if = ref_word(a);
        checks++; if (d !== last_if) begin failures++; $display("FAIL rnd_fetch[%0d]: addr %h got %h expected %h", i, a, d, last_if); end
        checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rnd_fetch_lat[%0d]: got %0d expected %0d", i, lat, exp_lat); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rnd_fetch_we[%0d]: got %b expected 0", i, we); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_din = '0;
    @(posedge clk); #1;
    bd_we = 1'b1;
    for (int a = 32'h100; a < 32'h400; a++) preload(a, 8'($urandom));
    for (int a = 32'h1FFFC; a < 32'h20000; a++) preload(a, 8'($urandom));
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    for (int a = 32'h200; a < 32'h204; a++) preload(a, 8'h00);
    bd_we = 1'b0;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    test_fetch;
    test_hold_extra;
    test_store;
    test_arbitration;
`ifdef MEM_CTRL_IF_BUF_EN
    test_buffer;
`endif
    test_reset_async;
    test_reset_mid_write;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller between the CPU core and the byte-wide single-port RAM inside openmips_min_sopc; it is the stage directly under the core that the SoC testbench drives through clk/rst.
- Arbitrates the instruction-fetch (IF) port and the data (MEM) port onto one RAM.
- Serialises each 32-bit word access into four byte transfers, little-endian.
- Gives each requester a done pulse; the core stalls on an asserted req with no done.

Parameters:
- ADDR_W, 17, RAM byte-address width (depth 2^ADDR_W bytes); address bits above ADDR_W-1 are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high (RstEnable = 1).
- if_req  in  1  instruction fetch request; held until if_done.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_data  out  32  fetched word; valid while if_done=1, held until the next IF completion.
- if_done  out  1  one-cycle completion pulse.
- mem_req  in  1  data request; held until mem_done.
- mem_we  in  1  1=store, 0=load.
- mem_addr  in  32  data byte address; bits [1:0] ignored.
- mem_sel  in  4  byte enables for stores; bit k selects byte k of the word.
- mem_wdata  in  32  store data; byte k = mem_wdata[8k+7:8k].
- mem_rdata  out  32  loaded word (all 4 bytes); valid while mem_done=1, held after.
- mem_done  out  1  one-cycle completion pulse.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_we  out  1  RAM write strobe.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, synchronous: data for the address presented at edge E appears after E.

Behaviour:
- States: IDLE, RD, WR, DONE. A 2-bit byte counter cnt and a latched base word address apply.
- Reset (async, immediate), all regs: state=IDLE, cnt=0, if_done=mem_done=0, if_data=mem_rdata=0, ram_addr=0, ram_we=0, ram_din=0.
- IDLE arbitration at each edge:
  - MEM wins over IF, since MEM is the older instruction.
  - If mem_req=1: latch mem_addr[ADDR_W-1:2], mem_we, mem_sel, mem_wdata; go to WR if mem_we=1, else RD.
  - Else if if_req=1: latch if_addr; go to RD with owner=IF.
  - Else stay in IDLE.
- RD: ram_addr = {base,cnt} for cnt=0..3 during the 4 cycles after acceptance. Byte cnt-1 is captured from ram_dout into the owner's data register lane cnt-1. The final byte is captured in the cycle after cnt=3. Then go to DONE.
  - Read latency: done high in the 6th cycle after the accepting edge (accept edge E0; done during E5–E6).
- WR: for cnt=0..3, drive ram_addr={base,cnt}, ram_din=byte cnt, and ram_we=mem_sel[cnt]. Unselected bytes spend a cycle with ram_we=0. Then go to DONE.
  - Write latency: done high during E4–E5.
- DONE: owner's done=1 for exactly one cycle, ram_we=0; then return to IDLE.
  - req inputs are ignored in DONE.
  - Requesters must drop req at the edge that samples done=1. A req still high in the following IDLE cycle is a new transaction.
- An IF request pending during a MEM transaction waits; it is accepted in the first IDLE after that MEM transaction unless mem_req is high again.
- Inputs other than req are latched at acceptance; changes during a transaction have no effect.
- Address wrap: base+cnt never crosses a word, so there is no carry into base. The top word of RAM is legal.
- mem_sel=0 store: runs 4 cycles with no writes, then mem_done as normal.
- Reset mid-transaction: aborts immediately, no further RAM writes, no done pulse; bytes already written stay in RAM.

Optional Feature:
- Macro MEM_CTRL_IF_BUF_EN.
- When defined: a one-entry fetch buffer holds the last IF word plus its word-address tag and a valid bit. Valid is cleared on reset.
  - IF request in IDLE, no mem_req, tag hit and valid: go straight to DONE, no RAM access; if_done appears the cycle after acceptance.
  - Any accepted store whose word address equals the tag clears valid.
  - Each IF miss refills the buffer.
- When undefined: no buffer; every fetch takes the full RD sequence.

Test Plan:
- Reset: assert rst mid-cycle at random time -> all outputs 0 immediately (async), before the next edge.
- RAM bytes 0x100..0x103 = 11,22,33,44; if_req with if_addr=0x100 -> if_done 1 cycle, 5 cycles after the accept edge; if_data=0x44332211; ram_we stays 0.
- Store mem_addr=0x200, mem_sel=4'b0101, mem_wdata=0xAABBCCDD over RAM pre-filled 0x00 -> RAM 0x200=DD, 0x201=00, 0x202=BB, 0x203=00; mem_done 4 cycles after accept; a load of 0x200 then returns mem_rdata=0x00BB00DD.
- if_req and mem_req (load 0x200) raised the same cycle -> MEM served first (mem_done), IF served next; if_done comes exactly 1 IDLE cycle after mem_done plus IF latency.
- Fetch 0x102 -> same result as 0x100 (low bits ignored); requester holds req an extra cycle after done -> second identical transaction starts.
- MEM_CTRL_IF_BUF_EN: fetch 0x100 twice -> second if_done the cycle after accept, ram_addr unchanged; store 0x100 with sel=4'b0001 data 0x000000EE, refetch -> full RD, if_data=0x443322EE.
